// File: rtl/matmul_io.sv
`default_nettype none
// ============================================================================
// Module   : matmul_io
// Purpose  : Streams X then Y matrices into the multiplier's memories, starts
//            the multiplier, then streams Z back out row-major.
//            Optional out_last port: define MATMUL_IO_OUT_LAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_io #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int Tn         = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  x_wr_en,
    output logic [ADDR_WIDTH-1:0] x_addr,
    output logic [DATA_WIDTH-1:0] x_din,
    output logic                  y_wr_en,
    output logic [ADDR_WIDTH-1:0] y_addr,
    output logic [DATA_WIDTH-1:0] y_din,
    output logic                  mm_start,
    input  logic                  mm_done,
    output logic [ADDR_WIDTH-1:0] z_addr,
    input  logic [DATA_WIDTH-1:0] z_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
`ifdef MATMUL_IO_OUT_LAST_EN
    output logic                  out_last,
`endif
    output logic                  busy
);

    localparam logic [ADDR_WIDTH:0] c_last = (ADDR_WIDTH+1)'(Tn*Tn - 1);
    localparam logic [ADDR_WIDTH:0] c_one  = (ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_X = 3'd1,
        S_LOAD_Y = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_RD     = 3'd5,
        S_CAP    = 3'd6,
        S_SEND   = 3'd7
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [ADDR_WIDTH:0]     r_n;
    logic [ADDR_WIDTH:0]     w_n_nxt;
    logic                    r_wait_armed;
    logic                    w_wait_armed_nxt;
    logic [DATA_WIDTH-1:0]   r_out_data;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_n          <= '0;
            r_wait_armed <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_n          <= w_n_nxt;
            r_wait_armed <= w_wait_armed_nxt;
            if (r_state == S_CAP) begin
                r_out_data <= z_dout;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_n_nxt          = r_n;
        w_wait_armed_nxt = 1'b0;
        in_ready         = 1'b0;
        x_wr_en          = 1'b0;
        x_addr           = '0;
        x_din            = '0;
        y_wr_en          = 1'b0;
        y_addr           = '0;
        y_din            = '0;
        mm_start         = 1'b0;
        z_addr           = '0;
        out_valid        = 1'b0;
        busy             = (r_state != S_IDLE);

        case (r_state)
            S_IDLE: begin
                // The word that wakes us is left on the bus for LOAD_X to take.
                if (in_valid) begin
                    w_state_nxt = S_LOAD_X;
                    w_n_nxt     = '0;
                end
            end
            S_LOAD_X: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_wr_en = 1'b1;
                    x_addr  = r_n[ADDR_WIDTH-1:0];
                    x_din   = in_data;
                    if (r_n == c_last) begin
                        w_state_nxt = S_LOAD_Y;
                        w_n_nxt     = '0;
                    end else begin
                        w_n_nxt = r_n + c_one;
                    end
                end
            end
            S_LOAD_Y: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    y_wr_en = 1'b1;
                    y_addr  = r_n[ADDR_WIDTH-1:0];
                    y_din   = in_data;
                    if (r_n == c_last) begin
                        w_state_nxt = S_START;
                        w_n_nxt     = '0;
                    end else begin
                        w_n_nxt = r_n + c_one;
                    end
                end
            end
            S_START: begin
                mm_start    = 1'b1;
                w_state_nxt = S_WAIT;
                w_n_nxt     = '0;
            end
            S_WAIT: begin
                // First WAIT cycle may still see done from the previous run.
                w_wait_armed_nxt = 1'b1;
                if (r_wait_armed && mm_done) begin
                    w_state_nxt      = S_RD;
                    w_n_nxt          = '0;
                    w_wait_armed_nxt = 1'b0;
                end
            end
            S_RD: begin
                z_addr      = r_n[ADDR_WIDTH-1:0];
                w_state_nxt = S_CAP;
            end
            S_CAP: begin
                w_state_nxt = S_SEND;
            end
            S_SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (r_n < c_last) begin
                        w_state_nxt = S_RD;
                        w_n_nxt     = r_n + c_one;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_n_nxt     = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_n_nxt     = '0;
            end
        endcase
    end

    assign out_data = r_out_data;

`ifdef MATMUL_IO_OUT_LAST_EN
    assign out_last = out_valid && (r_n == c_last);
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_io.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_io
// Purpose  : Randomized self-checking bench for matmul_io with a behavioural
//            matrix-multiplier/memory environment and reference product.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_io;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int TN = 8;
    localparam int NW = TN * TN;

    logic          clock;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          x_wr_en;
    logic [AW-1:0] x_addr;
    logic [DW-1:0] x_din;
    logic          y_wr_en;
    logic [AW-1:0] y_addr;
    logic [DW-1:0] y_din;
    logic          mm_start;
    logic          mm_done = 1'b1;
    logic [AW-1:0] z_addr;
    logic [DW-1:0] z_dout;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          busy;
`ifdef MATMUL_IO_OUT_LAST_EN
    logic          out_last;
`endif

    matmul_io #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .Tn(TN)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .x_wr_en   (x_wr_en),
        .x_addr    (x_addr),
        .x_din     (x_din),
        .y_wr_en   (y_wr_en),
        .y_addr    (y_addr),
        .y_din     (y_din),
        .mm_start  (mm_start),
        .mm_done   (mm_done),
        .z_addr    (z_addr),
        .z_dout    (z_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
`ifdef MATMUL_IO_OUT_LAST_EN
        .out_last  (out_last),
`endif
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stimulus matrices and the reference product Z = X * Y (row-major)
    logic [DW-1:0] xs [NW];
    logic [DW-1:0] ys [NW];
    logic [DW-1:0] expz [NW];

    task automatic compute_exp();
        logic [DW-1:0] acc;
        for (int r = 0; r < TN; r++) begin
            for (int c = 0; c < TN; c++) begin
                acc = '0;
                for (int k = 0; k < TN; k++) acc = acc + xs[r*TN+k] * ys[k*TN+c];
                expz[r*TN+c] = acc;
            end
        end
    endtask

    // Environment: X/Y/Z memories and a multiplier with fixed latency whose
    // done level drops one cycle after start and stays high after finishing.
    logic [DW-1:0] xm [NW];
    logic [DW-1:0] ym [NW];
    logic [DW-1:0] zm [NW];
    logic [DW-1:0] mm_acc;
    int            mm_cnt  = 0;
    logic          mm_pend = 1'b0;

    always @(posedge clock) begin
        z_dout <= zm[z_addr];
        if (x_wr_en) xm[x_addr] = x_din;
        if (y_wr_en) ym[y_addr] = y_din;
        if (mm_pend) begin
            mm_done <= 1'b0;
            mm_pend = 1'b0;
        end
        if (mm_start) begin
            for (int r = 0; r < TN; r++) begin
                for (int c = 0; c < TN; c++) begin
                    mm_acc = '0;
                    for (int k = 0; k < TN; k++) mm_acc = mm_acc + xm[r*TN+k] * ym[k*TN+c];
                    zm[r*TN+c] = mm_acc;
                end
            end
            mm_cnt  = 12;
            mm_pend = 1'b1;
        end else if (mm_cnt > 0) begin
            mm_cnt--;
            if (mm_cnt == 0) mm_done <= 1'b1;
        end
    end

    // Write-port monitor
    int x_cnt = 0;
    int y_cnt = 0;
    int viol_overlap = 0;
    int viol_nowrite = 0;
    int viol_idle_bus = 0;
    int early_out = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (x_wr_en && y_wr_en) viol_overlap++;
            if ((x_wr_en || y_wr_en) && !in_valid) viol_nowrite++;
            if (!x_wr_en && (x_addr != '0 || x_din != '0)) viol_idle_bus++;
            if (!y_wr_en && (y_addr != '0 || y_din != '0)) viol_idle_bus++;
            if (out_valid && mm_cnt > 0) early_out++;
            if (x_wr_en) begin
                check("x_addr", x_addr, x_cnt);
                check("x_din", x_din, xs[x_cnt % NW]);
                x_cnt++;
            end
            if (y_wr_en) begin
                check("y_addr", y_addr, y_cnt);
                check("y_din", y_din, ys[y_cnt % NW]);
                y_cnt++;
            end
        end
    end

    // Present X then Y words; gap = idle cycles between offered words.
    task automatic load(input int gap, input int limit);
        int idx, ph, cyc;
        logic xfer;
        idx = 0; ph = 0; cyc = 0;
        while (idx < limit && cyc < 5000) begin
            in_valid = ((ph % (gap + 1)) == 0);
            in_data  = (idx < NW) ? xs[idx] : ys[(idx - NW) % NW];
            ph++;
            @(negedge clock);
            xfer = in_valid && in_ready;
            @(posedge clock); #1;
            cyc++;
            if (xfer) idx++;
        end
        in_valid = 1'b0;
        check("load_done", idx, limit);
    endtask

    // mode 0: always ready; 1: random ready; 2: ready except 10-cycle stall at word 5
    task automatic recv(input int mode);
        int w, cyc, stall, first_hs, last_hs;
        logic [DW-1:0] held;
        w = 0; cyc = 0; stall = 0; first_hs = 0; last_hs = 0; held = '0;
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (w < NW && cyc < 20000) begin
            @(negedge clock);
            cyc++;
            if (out_valid && out_ready) begin
                check("out_data", out_data, expz[w]);
`ifdef MATMUL_IO_OUT_LAST_EN
                check("out_last", out_last, (w == NW - 1));
`endif
                if (w == 0) first_hs = cyc;
                last_hs = cyc;
                w++;
            end else if (out_valid && mode == 2 && w == 5) begin
                if (stall == 0) begin
                    held = out_data;
                    check("stall_data", out_data, expz[5]);
                end else begin
                    check("stall_hold", out_data, held);
                end
                check("stall_zaddr", z_addr, 0);
                stall++;
`ifdef MATMUL_IO_OUT_LAST_EN
            end else if (out_valid) begin
                check("out_last_wait", out_last, (w == NW - 1));
`endif
            end
            @(posedge clock); #1;
            if (mode == 1) out_ready = 1'($urandom_range(0, 1));
            else           out_ready = !(mode == 2 && w == 5 && stall < 10);
        end
        check("recv_words", w, NW);
        if (mode == 0) check("throughput", last_hs - first_hs, 3 * (NW - 1));
        if (mode == 2) check("stall_cycles", stall, 10);
        check("idle_after", busy, 1'b0);
        out_ready = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_in_ready"},  in_ready,  1'b0);
        check({tag, "_x_wr_en"},   x_wr_en,   1'b0);
        check({tag, "_y_wr_en"},   y_wr_en,   1'b0);
        check({tag, "_mm_start"},  mm_start,  1'b0);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_busy"},      busy,      1'b0);
        check({tag, "_out_data"},  out_data,  '0);
        check({tag, "_z_addr"},    z_addr,    '0);
    endtask

    task automatic randomize_mats();
        for (int k = 0; k < NW; k++) begin
            xs[k] = $urandom;
            ys[k] = $urandom;
        end
        compute_exp();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        // Identity X, signed ramp Y: output must equal Y
        for (int k = 0; k < NW; k++) begin
            xs[k] = ((k / TN) == (k % TN)) ? 32'd1 : 32'd0;
            ys[k] = 32'(k - 3);
        end
        compute_exp();
        x_cnt = 0; y_cnt = 0;
        load(0, 2 * NW);
        recv(0);
        check("a_x_writes", x_cnt, NW);
        check("a_y_writes", y_cnt, NW);

        // Random matrices, 1-on/2-off input, stall at word 5, stale done held high
        randomize_mats();
        x_cnt = 0; y_cnt = 0;
        load(2, 2 * NW);
        recv(2);
        check("b_x_writes", x_cnt, NW);
        check("b_y_writes", y_cnt, NW);

        // Reset after 40 X writes, then a complete reload from address 0
        randomize_mats();
        x_cnt = 0; y_cnt = 0;
        load(0, 40);
        in_valid = 1'b1;
        reset    = 1'b1;
        #1;
        check_all_zero("midload");
        check("c_partial_writes", x_cnt, 40);
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        randomize_mats();
        x_cnt = 0; y_cnt = 0;
        load($urandom_range(0, 1), 2 * NW);
        recv(1);
        check("c_x_writes", x_cnt, NW);
        check("c_y_writes", y_cnt, NW);

        check("no_overlap", viol_overlap, 0);
        check("no_write_off", viol_nowrite, 0);
        check("idle_bus_zero", viol_idle_bus, 0);
        check("no_early_rd", early_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matmul_io.md
MATMUL_IO -- requirements
Module: matmul_io

Interface
REQ-001 The block SHALL have parameters: DATA_WIDTH, default 32, element width; ADDR_WIDTH, default 6, memory address width; Tn, default 8, square matrix dimension.
REQ-002 The block SHALL have port clock, input, 1, rising-edge clock.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, DATA_WIDTH), forming the element input stream.
REQ-005 The block SHALL have ports x_wr_en (output, 1), x_addr (output, ADDR_WIDTH) and x_din (output, DATA_WIDTH), forming the X memory write port.
REQ-006 The block SHALL have ports y_wr_en (output, 1), y_addr (output, ADDR_WIDTH) and y_din (output, DATA_WIDTH), forming the Y memory write port.
REQ-007 The block SHALL have ports mm_start (output, 1), a multiplier start pulse, and mm_done (input, 1), the multiplier done level.
REQ-008 The block SHALL have ports z_addr (output, ADDR_WIDTH) and z_dout (input, DATA_WIDTH), forming the Z memory read port with 1-cycle synchronous read.
REQ-009 The block SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, DATA_WIDTH), forming the result output stream.
REQ-010 The block SHALL have port busy, output, 1, high whenever state is not IDLE.

Function
REQ-011 The block SHALL implement FSM states IDLE, LOAD_X, LOAD_Y, START, WAIT, RD, CAP and SEND, with a single element counter n of ADDR_WIDTH+1 bits.
REQ-012 In IDLE, in_valid=1 SHALL cause a transition to LOAD_X with n=0; that first word is not consumed in IDLE (in_ready=0 in IDLE).
REQ-013 In LOAD_X/LOAD_Y, in_ready SHALL be 1; a transfer (in_valid&&in_ready) SHALL drive the wr_en of the current memory combinationally, with addr=n and din=in_data, then increment n.
REQ-014 A transfer at n=Tn*Tn-1 SHALL move LOAD_X->LOAD_Y or LOAD_Y->START, resetting n to 0; words are row-major (addr=row*Tn+col), X first, then Y.
REQ-015 Cycles without a transfer SHALL hold state and n; x_wr_en and y_wr_en SHALL never be high together.
REQ-016 START SHALL assert mm_start for exactly one cycle and then enter WAIT.
REQ-017 WAIT SHALL ignore mm_done in its first cycle (a stale done from a prior run is discarded); from the second cycle onward, mm_done=1 SHALL move to RD with n=0.
REQ-018 RD SHALL drive z_addr=n for one cycle and go to CAP; CAP SHALL register z_dout into out_data and go to SEND.
REQ-019 SEND SHALL hold out_valid=1 with out_data stable until out_ready=1; on handshake, n<Tn*Tn-1 SHALL go to RD with n+1, and otherwise to IDLE.
REQ-020 Output order SHALL be z address 0..Tn*Tn-1; throughput is 1 word per 3 cycles with out_ready held high.
REQ-021 z_addr SHALL be 0 outside RD; x/y addr/din SHALL be 0 when the corresponding wr_en=0.
REQ-022 Data SHALL pass through unmodified (no arithmetic); the counter width SHALL hold Tn*Tn, and Tn*Tn SHALL be <= 2^ADDR_WIDTH.
REQ-023 in_valid while not in LOAD states SHALL be ignored (in_ready=0, no write).

Reset
REQ-024 Reset assertion at any time, including mid-load or mid-send, SHALL immediately force IDLE, n=0, out_data=0, and all outputs 0 (in_ready, wr_ens, mm_start, out_valid, busy).
REQ-025 After reset, partially loaded memory contents are undefined, and a new load SHALL restart at address 0.

Configuration
REQ-026 With macro MATMUL_IO_OUT_LAST_EN defined, the block SHALL add output port out_last (1 bit), high together with out_valid only for the final word (n=Tn*Tn-1) and 0 at reset.
REQ-027 Without MATMUL_IO_OUT_LAST_EN, port out_last SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-028 Load X=identity and Y[k]=k-3 (signed, k=0..63) with in_valid always 1, connect a matmul model -> output stream is 64 words equal to Y, in order, including negatives.
REQ-029 Drive in_valid with a 1-on/2-off pattern -> exactly 128 writes occur, addresses 0..63 on X then 0..63 on Y, with no write in off cycles.
REQ-030 Hold out_ready=0 for 10 cycles in SEND at word 5 -> out_valid and out_data (=Z[5]) are stable, and no z_addr change occurs until the handshake.
REQ-031 Hold mm_done=1 before START -> the block remains in WAIT until mm_done falls and rises again; RD is not entered early.
REQ-032 Assert reset after 40 X writes -> all outputs are 0 next cycle and busy=0; a new 128-word load writes from address 0.
REQ-033 With MATMUL_IO_OUT_LAST_EN defined -> out_last=1 only on word 63; a build without the macro compiles without the port.
